// File: rtl/pe_array_tile_sched_if.sv
// pe_array_tile_sched_if: job config, operand-read, array-control and writeback signals of the tile scheduler.
// The perf counter signals exist only when TILE_SCHED_PERF_EN is defined.
interface pe_array_tile_sched_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [CNT_W-1:0]  cfg_m_tiles;
    logic [CNT_W-1:0]  cfg_n_tiles;
    logic [CNT_W-1:0]  cfg_k_tiles;
    logic [ADDR_W-1:0] cfg_a_base;
    logic [ADDR_W-1:0] cfg_b_base;
    logic [ADDR_W-1:0] cfg_c_base;
    logic [1:0]        cfg_mode;
    logic              a_rd_en;
    logic [ADDR_W-1:0] a_rd_addr;
    logic              b_rd_en;
    logic [ADDR_W-1:0] b_rd_addr;
    logic              arr_valid_in;
    logic              arr_acc_zero;
    logic [1:0]        pe_mode;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_ready;
    logic              busy;
    logic              done;
    logic              err_cfg;
`ifdef TILE_SCHED_PERF_EN
    logic [31:0]       perf_busy_cyc;
    logic [31:0]       perf_wb_stall;
`endif

    modport master (
        output start, cfg_m_tiles, cfg_n_tiles, cfg_k_tiles, cfg_a_base, cfg_b_base, cfg_c_base, cfg_mode, wb_ready,
        input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, arr_valid_in, arr_acc_zero, pe_mode,
        input  wb_valid, wb_addr, busy, done, err_cfg
`ifdef TILE_SCHED_PERF_EN
        , input perf_busy_cyc, perf_wb_stall
`endif
    );

    modport slave (
        input  start, cfg_m_tiles, cfg_n_tiles, cfg_k_tiles, cfg_a_base, cfg_b_base, cfg_c_base, cfg_mode, wb_ready,
        output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, arr_valid_in, arr_acc_zero, pe_mode,
        output wb_valid, wb_addr, busy, done, err_cfg
`ifdef TILE_SCHED_PERF_EN
        , output perf_busy_cyc, perf_wb_stall
`endif
    );
endinterface

// File: rtl/pe_array_tile_sched.sv
// pe_array_tile_sched: sequences k/n/m tile loops for the PE array, driving operand reads, array control and writeback.
// Define TILE_SCHED_PERF_EN to add busy-cycle and writeback-stall counters.
module pe_array_tile_sched #(
    parameter int TILE_SIZE = 4,
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_array_tile_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WB, DONE} state_t;

    if (TILE_SIZE < 1) begin : g_bad_tile_size
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  k_cnt_q, k_cnt_d, n_cnt_q, n_cnt_d, m_cnt_q, m_cnt_d;
    logic [CNT_W-1:0]  k_tiles_q, k_tiles_d, n_tiles_q, n_tiles_d, m_tiles_q, m_tiles_d;
    logic [ADDR_W-1:0] a_row_q, a_row_d, b_col_q, b_col_d, b_base_q, b_base_d;
    logic              drain_q, drain_d;
    logic              a_rd_en_q, a_rd_en_d;
    logic [ADDR_W-1:0] a_rd_addr_q, a_rd_addr_d, b_rd_addr_q, b_rd_addr_d;
    logic              arr_valid_q, arr_valid_d, acc_zero_q, acc_zero_d;
    logic [1:0]        pe_mode_q, pe_mode_d;
    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic              busy_q, busy_d, done_q, done_d, err_cfg_q, err_cfg_d;
    logic              start_ok, last_k, last_n, last_m, accept;

    assign start_ok = (|bus.cfg_m_tiles) & (|bus.cfg_n_tiles) & (|bus.cfg_k_tiles);
    assign last_k   = k_cnt_q == k_tiles_q - CNT_W'(1);
    assign last_n   = n_cnt_q == n_tiles_q - CNT_W'(1);
    assign last_m   = m_cnt_q == m_tiles_q - CNT_W'(1);
    assign accept   = wb_valid_q & bus.wb_ready;

    always_comb begin
        state_d     = state_q;
        k_cnt_d     = k_cnt_q;
        n_cnt_d     = n_cnt_q;
        m_cnt_d     = m_cnt_q;
        k_tiles_d   = k_tiles_q;
        n_tiles_d   = n_tiles_q;
        m_tiles_d   = m_tiles_q;
        a_row_d     = a_row_q;
        b_col_d     = b_col_q;
        b_base_d    = b_base_q;
        drain_d     = drain_q;
        a_rd_en_d   = 1'b0;
        a_rd_addr_d = a_rd_addr_q;
        b_rd_addr_d = b_rd_addr_q;
        pe_mode_d   = pe_mode_q;
        wb_addr_d   = wb_addr_q;
        err_cfg_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d     = start_ok ? ISSUE : DONE;
                err_cfg_d   = !start_ok;
                a_rd_en_d   = start_ok;
                k_cnt_d     = '0;
                n_cnt_d     = '0;
                m_cnt_d     = '0;
                k_tiles_d   = bus.cfg_k_tiles;
                n_tiles_d   = bus.cfg_n_tiles;
                m_tiles_d   = bus.cfg_m_tiles;
                a_row_d     = bus.cfg_a_base;
                b_col_d     = bus.cfg_b_base;
                b_base_d    = bus.cfg_b_base;
                a_rd_addr_d = bus.cfg_a_base;
                b_rd_addr_d = bus.cfg_b_base;
                wb_addr_d   = bus.cfg_c_base;
                pe_mode_d   = bus.cfg_mode;
            end
            ISSUE: begin
                state_d     = last_k ? DRAIN : ISSUE;
                a_rd_en_d   = !last_k;
                k_cnt_d     = last_k ? '0 : k_cnt_q + CNT_W'(1);
                drain_d     = 1'b0;
                a_rd_addr_d = last_k ? a_rd_addr_q : a_rd_addr_q + ADDR_W'(1);
                b_rd_addr_d = last_k ? b_rd_addr_q : b_rd_addr_q + ADDR_W'(n_tiles_q);
            end
            DRAIN: begin
                drain_d = 1'b1;
                state_d = drain_q ? WB : DRAIN;
            end
            WB: if (accept) begin
                wb_addr_d = wb_addr_q + ADDR_W'(1);
                if (last_n && last_m) begin
                    state_d = DONE;
                end else begin
                    // n advances within an output row; a row change steps A by K_T and rewinds B to its base column
                    state_d     = ISSUE;
                    a_rd_en_d   = 1'b1;
                    n_cnt_d     = last_n ? '0 : n_cnt_q + CNT_W'(1);
                    m_cnt_d     = last_n ? m_cnt_q + CNT_W'(1) : m_cnt_q;
                    a_row_d     = last_n ? a_row_q + ADDR_W'(k_tiles_q) : a_row_q;
                    b_col_d     = last_n ? b_base_q : b_col_q + ADDR_W'(1);
                    a_rd_addr_d = a_row_d;
                    b_rd_addr_d = b_col_d;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        arr_valid_d = a_rd_en_q;
        acc_zero_d  = a_rd_en_q & (k_cnt_q == '0);
        wb_valid_d  = state_d == WB;
        busy_d      = state_d != IDLE;
        done_d      = state_d == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_cnt_q     <= '0;
            n_cnt_q     <= '0;
            m_cnt_q     <= '0;
            k_tiles_q   <= '0;
            n_tiles_q   <= '0;
            m_tiles_q   <= '0;
            a_row_q     <= '0;
            b_col_q     <= '0;
            b_base_q    <= '0;
            drain_q     <= 1'b0;
            a_rd_en_q   <= 1'b0;
            a_rd_addr_q <= '0;
            b_rd_addr_q <= '0;
            arr_valid_q <= 1'b0;
            acc_zero_q  <= 1'b0;
            pe_mode_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_cfg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            n_cnt_q     <= n_cnt_d;
            m_cnt_q     <= m_cnt_d;
            k_tiles_q   <= k_tiles_d;
            n_tiles_q   <= n_tiles_d;
            m_tiles_q   <= m_tiles_d;
            a_row_q     <= a_row_d;
            b_col_q     <= b_col_d;
            b_base_q    <= b_base_d;
            drain_q     <= drain_d;
            a_rd_en_q   <= a_rd_en_d;
            a_rd_addr_q <= a_rd_addr_d;
            b_rd_addr_q <= b_rd_addr_d;
            arr_valid_q <= arr_valid_d;
            acc_zero_q  <= acc_zero_d;
            pe_mode_q   <= pe_mode_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_cfg_q   <= err_cfg_d;
        end
    end

    assign bus.a_rd_en      = a_rd_en_q;
    assign bus.a_rd_addr    = a_rd_addr_q;
    assign bus.b_rd_en      = a_rd_en_q;
    assign bus.b_rd_addr    = b_rd_addr_q;
    assign bus.arr_valid_in = arr_valid_q;
    assign bus.arr_acc_zero = acc_zero_q;
    assign bus.pe_mode      = pe_mode_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_addr      = wb_addr_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err_cfg      = err_cfg_q;

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;
    logic        perf_clr;

    assign perf_clr = (state_q == IDLE) & bus.start;

    always_comb begin
        perf_busy_d  = perf_clr ? '0 : (busy_q && !(&perf_busy_q)) ? perf_busy_q + 32'd1 : perf_busy_q;
        perf_stall_d = perf_clr ? '0 : (wb_valid_q && !bus.wb_ready && !(&perf_stall_q)) ? perf_stall_q + 32'd1 : perf_stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign bus.perf_busy_cyc = perf_busy_q;
    assign bus.perf_wb_stall = perf_stall_q;
`endif
endmodule
